// File: rtl/ppu_pkg.sv
// Shared PPU3 types: pixel entry, tile row width and mode encoding.
package ppu_pkg;

  localparam int TILE_ROW   = 8;
  localparam int PPU_PX_W   = 2;
  localparam int PPU_ATTR_W = 4;

  typedef struct packed {
    logic [PPU_PX_W-1:0]   px;
    logic [PPU_ATTR_W-1:0] attr;
  } ppu_px_t;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_DRAW   = 2'd3
  } ppu_mode_t;

endpackage

// File: rtl/ppu_row_decode.sv
// Bitplane pair to pixel array; pixel 0 comes from the MSBs.
module ppu_row_decode
  import ppu_pkg::*;
#(
  parameter int ROW  = TILE_ROW,
  parameter int PX_W = PPU_PX_W
) (
  input  logic [ROW-1:0]           lo,
  input  logic [ROW-1:0]           hi,
  output logic [ROW-1:0][PX_W-1:0] px
);

  always_comb begin
    for (int i = 0; i < ROW; i++) begin
      px[i] = PX_W'({hi[ROW-1-i], lo[ROW-1-i]});
    end
  end

endmodule

// File: rtl/ppu_pixel_fifo.sv
// Pixel shift FIFO for the DRAW stage: row push, sprite merge,
// fine-scroll discard and synchronous flush.
module ppu_pixel_fifo
  import ppu_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int ROW    = TILE_ROW,
  parameter  int PX_W   = PPU_PX_W,
  parameter  int ATTR_W = PPU_ATTR_W,
  localparam int CW     = $clog2(DEPTH+1),
  localparam int DW     = $clog2(ROW)
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              clear,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [ROW-1:0]    push_lo,
  input  logic [ROW-1:0]    push_hi,
  input  logic [ATTR_W-1:0] push_attr,
  input  logic              merge_valid,
  input  logic [ROW-1:0]    merge_lo,
  input  logic [ROW-1:0]    merge_hi,
  input  logic [ATTR_W-1:0] merge_attr,
  input  logic              discard_valid,
  input  logic [DW-1:0]     discard_n,
  input  logic              pop,
  output logic              pop_ready,
  output logic [PX_W-1:0]   head_px,
  output logic [ATTR_W-1:0] head_attr,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);

  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [PX_W-1:0]   px;
    logic [ATTR_W-1:0] attr;
  } ent_t;

  ent_t mem     [DEPTH];
  ent_t mem_nxt [DEPTH];

  logic [CW-1:0] cnt, cnt_nxt, base;
  logic [DW-1:0] disc, disc_nxt;
  logic [ROW-1:0][PX_W-1:0] push_px;
  logic [ROW-1:0][PX_W-1:0] merge_px;
  logic drop, pop_fire, push_fire, shift;

  ppu_row_decode #(.ROW(ROW), .PX_W(PX_W)) u_push_dec (
    .lo (push_lo),
    .hi (push_hi),
    .px (push_px)
  );

  ppu_row_decode #(.ROW(ROW), .PX_W(PX_W)) u_merge_dec (
    .lo (merge_lo),
    .hi (merge_hi),
    .px (merge_px)
  );

  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

  assign drop = !clear && !merge_valid
             && (disc != '0) && !empty;
  assign pop_ready = !empty && (disc == '0)
                  && !merge_valid && !clear;
  assign push_ready = (cnt <= CW'(DEPTH-ROW))
                   && !merge_valid && !clear;

  assign pop_fire  = pop && pop_ready;
  assign push_fire = push_valid && push_ready;
  assign shift     = pop_fire || drop;

  assign head_px   = empty ? '0 : mem[0].px;
  assign head_attr = empty ? '0 : mem[0].attr;

  always_comb begin
    mem_nxt  = mem;
    cnt_nxt  = cnt;
    disc_nxt = disc;
    base     = cnt - CW'(shift);
    if (clear) begin
      cnt_nxt  = '0;
      disc_nxt = '0;
    end else if (merge_valid) begin
      // Slots past the tail are rewritten; live slots keep an opaque pixel
      for (int i = 0; i < ROW; i++) begin
        if (CW'(i) >= cnt) begin
          if (merge_px[i] != '0) begin
            mem_nxt[i].px   = merge_px[i];
            mem_nxt[i].attr = merge_attr;
          end else begin
            mem_nxt[i] = '0;
          end
        end else if (merge_px[i] != '0 && mem[i].px == '0) begin
          mem_nxt[i].px   = merge_px[i];
          mem_nxt[i].attr = merge_attr;
        end
      end
      cnt_nxt = (cnt > CW'(ROW)) ? cnt : CW'(ROW);
      if (discard_valid) disc_nxt = discard_n;
    end else begin
      if (shift) begin
        for (int j = 0; j < DEPTH-1; j++) begin
          mem_nxt[j] = mem[j+1];
        end
        mem_nxt[DEPTH-1] = '0;
      end
      if (push_fire) begin
        for (int k = 0; k < ROW; k++) begin
          mem_nxt[IW'(int'(base) + k)].px   = push_px[k];
          mem_nxt[IW'(int'(base) + k)].attr = push_attr;
        end
      end
      cnt_nxt = cnt
              + (push_fire ? CW'(ROW) : '0)
              - CW'(shift);
      disc_nxt = discard_valid ? discard_n
                               : disc - DW'(drop);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt  <= '0;
      disc <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      cnt  <= cnt_nxt;
      disc <= disc_nxt;
      mem  <= mem_nxt;
    end
  end

endmodule

// File: doc/ppu_pixel_fifo.md
Name: ppu_pixel_fifo

Overview:
- Parametrised pixel FIFO for the PPU3 DRAW stage; one instance serves as the background FIFO, another as the sprite FIFO.
- Accepts a whole decoded tile row (ROW pixels, two bitplane bytes) in one push and emits one pixel per pop.
- Adds three mechanisms for the PPU: sprite overlay merge onto the head with transparency rules, a fine-scroll discard of 0..ROW-1 leading pixels, and a synchronous flush used on window start and line end.

Parameters:
- DEPTH, 16, pixel entries stored; must satisfy DEPTH >= ROW.
- ROW, 8, pixels per tile row and per push/merge.
- PX_W, 2, colour-index bits per pixel.
- ATTR_W, 4, attribute bits per pixel (palette select, BG priority); stored, never interpreted.

Ports:
- clk  in  1  clock
- rstN  in  1  reset
- clear  in  1  synchronous flush
- push_valid  in  1  row push request
- push_ready  out  1  push accepted this cycle when high together with push_valid
- push_lo  in  ROW  bitplane 0 byte
- push_hi  in  ROW  bitplane 1 byte
- push_attr  in  ATTR_W  attribute applied to all pushed pixels
- merge_valid  in  1  sprite overlay request; always accepted
- merge_lo  in  ROW  sprite bitplane 0
- merge_hi  in  ROW  sprite bitplane 1
- merge_attr  in  ATTR_W  sprite attribute
- discard_valid  in  1  load fine-scroll discard count
- discard_n  in  $clog2(ROW)  pixels to drop from the head
- pop  in  1  consume head pixel
- pop_ready  out  1  head is valid and a pop is honoured this cycle
- head_px  out  PX_W  head colour index; 0 when empty
- head_attr  out  ATTR_W  head attribute; 0 when empty
- count  out  $clog2(DEPTH+1)  occupancy
- empty  out  1  count == 0
- full  out  1  count == DEPTH

Behaviour:
- Reset: rstN is asynchronous and active-low; clock is clk. On reset, all entries and count clear to 0, and the discard counter clears to 0.
  - Reset values: empty=1, full=0, head_px=0, head_attr=0, count=0, pop_ready=0.
  - push_ready=1 once reset is released.
  - If reset is asserted mid-operation, all state is lost and no partial push or merge survives.
- Storage: a shift array of {px, attr} with entry 0 as the head. All state changes at posedge clk. Head outputs are combinational from entry 0.
- Row decode: pixel i (i=0 is the first one out) = {hi[ROW-1-i], lo[ROW-1-i]}. This applies to both push and merge.
- Priority per cycle: clear > merge > discard > pop/push.
- clear: sets count and discard counter to 0. Any push, merge or pop in the same cycle is ignored.
- merge, when accepted:
  - Push and pop are ignored that cycle; push_ready=0 and pop_ready=0.
  - For each position i < ROW: if i >= count, entry i is written {mpx_i, merge_attr} when mpx_i != 0, else {0,0}. If i < count, entry i is overwritten only when mpx_i != 0 and the existing px == 0, so the earlier sprite wins.
  - After the merge, count = max(count, ROW).
- Discard:
  - discard_valid loads the discard counter with discard_n.
  - While the counter is nonzero and count > 0, one head entry is dropped per cycle and the counter decrements. pop_ready=0 and pops are ignored during this.
  - Push is still allowed during a discard.
  - A discard_valid in the same cycle as clear is dropped.
- pop_ready = !empty && discard counter == 0 && !merge_valid && !clear.
- push_ready = count <= DEPTH-ROW && !merge_valid && !clear. This is computed from pre-pop occupancy, with no same-cycle credit.
- Pushed pixels are appended at index count, or at count-1 when a pop or discard drop occurs in the same cycle.
- Count update: count += ROW·push_fire − pop_fire − drop_fire. The result never exceeds DEPTH and never wraps below 0.
- pop or discard while empty: no effect.
- push while not ready: ignored, and the data is not latched.
- Latency: a pushed row is visible at head_px on the next cycle if the FIFO was empty.

Decomposition:
- Package ppu_pkg:
  - typedef ppu_px_t struct {logic [PX_W-1:0] px; logic [ATTR_W-1:0] attr;}.
  - Constant TILE_ROW=8.
  - Enum for the PPU3 mode encoding, shared with PPU3.
- Sub-module ppu_row_decode (ROW, PX_W): bitplane pair to pixel array, combinational. Instantiated twice, once for push and once for merge.

Test Plan:
- Push lo=8'hF0, hi=8'hCC into an empty FIFO, then pop 8 times -> head_px sequence 3,3,1,1,2,2,0,0; count 8→0; empty=1 after the last pop.
- Push two rows (count=16, full=1), then hold push_valid -> push_ready=0 and count stays 16. Pop once -> count=15, push_ready stays 0 until count<=8.
- Push lo=8'h00, hi=8'hFF (all px=2); merge lo=8'hAA, hi=8'h00 -> head sequence 2,2,2,… unchanged. Then clear, push lo=hi=8'h00, and repeat the merge -> sequence 1,0,1,0,1,0,1,0 with merge_attr on the px=1 entries.
- Merge lo=8'h80, hi=8'h00 into an empty FIFO -> count=8, head_px=1, next 7 pixels are 0.
- Push row 3,3,1,1,2,2,0,0, discard_n=3, pop held high -> pop_ready low for 3 cycles, then head sequence 1,2,2,0,0.
- Push a row, assert clear and push_valid in the same cycle -> count=0 next cycle. Assert rstN low mid-discard -> all outputs at reset values immediately.
